// File: rtl/hyper_evt_tracker.sv
// Per-channel HyperBus transfer tracker: queues launch direction, pairs each end-of-transfer
// with the oldest outstanding launch and emits read/write completion pulses and counts.
module hyper_evt_tracker #(
    parameter int unsigned NB_CH = 2,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                               sys_clk_i,
    input  logic                               rstn_i,
    input  logic [NB_CH-1:0]                   rx_evt_i,
    input  logic [NB_CH-1:0]                   tx_evt_i,
    input  logic [NB_CH-1:0]                   eot_i,
    input  logic [NB_CH-1:0]                   clr_i,
    input  logic                               cnt_clr_i,
    output logic [NB_CH-1:0]                   evt_rd_done_o,
    output logic [NB_CH-1:0]                   evt_wr_done_o,
    output logic [NB_CH-1:0]                   pending_o,
    output logic [NB_CH*$clog2(DEPTH+1)-1:0]   level_o,
    output logic [NB_CH*CNT_W-1:0]             rd_cnt_o,
    output logic [NB_CH*CNT_W-1:0]             wr_cnt_o,
    output logic [NB_CH-1:0]                   ovf_o,
    output logic [NB_CH-1:0]                   unf_o,
    output logic [NB_CH-1:0]                   conflict_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    for (genvar c = 0; c < NB_CH; c++) begin : g_ch
        logic [DEPTH-1:0] mem_q;
        logic [PTR_W-1:0] wptr_q;
        logic [PTR_W-1:0] rptr_q;
        logic [LVL_W-1:0] level_q;
        logic [LVL_W-1:0] level_d;
        logic [CNT_W-1:0] rd_cnt_q;
        logic [CNT_W-1:0] wr_cnt_q;
        logic             pending_q;
        logic             rd_done_q;
        logic             wr_done_q;
        logic             ovf_q;
        logic             unf_q;
        logic             conflict_q;

        logic push_req;
        logic push_ok;
        logic pop;
        logic head;
        logic empty;
        logic full;
        logic drop;
        logic rd_inc;
        logic wr_inc;

        always_comb begin
            push_req = rx_evt_i[c] ^ tx_evt_i[c];
            empty    = (level_q == '0);
            full     = (level_q == LVL_W'(DEPTH));
            head     = mem_q[rptr_q];
            pop      = eot_i[c] & ~empty;
            // A pop in the same cycle frees the slot, so a push into a full queue still lands.
            push_ok  = push_req & (~full | pop);
            drop     = push_req & full & ~pop;
            rd_inc   = ~clr_i[c] & pop & head;
            wr_inc   = ~clr_i[c] & pop & ~head;
            level_d  = level_q;
            if (push_ok && !pop) begin
                level_d = level_q + LVL_W'(1);
            end else if (pop && !push_ok) begin
                level_d = level_q - LVL_W'(1);
            end
        end

        always_ff @(posedge sys_clk_i) begin
            if (!rstn_i) begin
                mem_q      <= '0;
                wptr_q     <= '0;
                rptr_q     <= '0;
                level_q    <= '0;
                pending_q  <= 1'b0;
                rd_done_q  <= 1'b0;
                wr_done_q  <= 1'b0;
                ovf_q      <= 1'b0;
                unf_q      <= 1'b0;
                conflict_q <= 1'b0;
                rd_cnt_q   <= '0;
                wr_cnt_q   <= '0;
            end else begin
                if (clr_i[c]) begin
                    wptr_q     <= '0;
                    rptr_q     <= '0;
                    level_q    <= '0;
                    pending_q  <= 1'b0;
                    rd_done_q  <= 1'b0;
                    wr_done_q  <= 1'b0;
                    ovf_q      <= 1'b0;
                    unf_q      <= 1'b0;
                    conflict_q <= 1'b0;
                end else begin
                    if (push_ok) begin
                        mem_q[wptr_q] <= rx_evt_i[c];
                        wptr_q        <= wptr_q + PTR_W'(1);
                    end
                    if (pop) begin
                        rptr_q <= rptr_q + PTR_W'(1);
                    end
                    level_q    <= level_d;
                    pending_q  <= (level_d != '0);
                    rd_done_q  <= pop & head;
                    wr_done_q  <= pop & ~head;
                    ovf_q      <= ovf_q | drop;
                    unf_q      <= unf_q | (eot_i[c] & empty);
                    conflict_q <= conflict_q | (rx_evt_i[c] & tx_evt_i[c]);
                end
                // Counters advance on the same edge that raises the matching done pulse.
                if (cnt_clr_i) begin
                    rd_cnt_q <= '0;
                    wr_cnt_q <= '0;
                end else begin
                    if (rd_inc && !(&rd_cnt_q)) begin
                        rd_cnt_q <= rd_cnt_q + CNT_W'(1);
                    end
                    if (wr_inc && !(&wr_cnt_q)) begin
                        wr_cnt_q <= wr_cnt_q + CNT_W'(1);
                    end
                end
            end
        end

        assign evt_rd_done_o[c]                 = rd_done_q;
        assign evt_wr_done_o[c]                 = wr_done_q;
        assign pending_o[c]                     = pending_q;
        assign level_o[c*LVL_W +: LVL_W]        = level_q;
        assign rd_cnt_o[c*CNT_W +: CNT_W]       = rd_cnt_q;
        assign wr_cnt_o[c*CNT_W +: CNT_W]       = wr_cnt_q;
        assign ovf_o[c]                         = ovf_q;
        assign unf_o[c]                         = unf_q;
        assign conflict_o[c]                    = conflict_q;
    end

endmodule

// File: tb/tb_hyper_evt_tracker.sv
// Directed bench for hyper_evt_tracker: two channels, depth 4, 2-bit counters so that
// counter saturation is reachable with a handful of transfers.
module tb_hyper_evt_tracker;

    localparam int unsigned NB_CH = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned LVL_W = 3;

    logic                     sys_clk = 1'b0;
    logic                     rstn;
    logic [NB_CH-1:0]         rx_evt;
    logic [NB_CH-1:0]         tx_evt;
    logic [NB_CH-1:0]         eot;
    logic [NB_CH-1:0]         clr;
    logic                     cnt_clr;
    logic [NB_CH-1:0]         rd_done;
    logic [NB_CH-1:0]         wr_done;
    logic [NB_CH-1:0]         pending;
    logic [NB_CH*LVL_W-1:0]   level;
    logic [NB_CH*CNT_W-1:0]   rd_cnt;
    logic [NB_CH*CNT_W-1:0]   wr_cnt;
    logic [NB_CH-1:0]         ovf;
    logic [NB_CH-1:0]         unf;
    logic [NB_CH-1:0]         conflict;

    int n_checks = 0;
    int n_fails  = 0;

    hyper_evt_tracker #(
        .NB_CH(NB_CH),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) u_dut (
        .sys_clk_i     (sys_clk),
        .rstn_i        (rstn),
        .rx_evt_i      (rx_evt),
        .tx_evt_i      (tx_evt),
        .eot_i         (eot),
        .clr_i         (clr),
        .cnt_clr_i     (cnt_clr),
        .evt_rd_done_o (rd_done),
        .evt_wr_done_o (wr_done),
        .pending_o     (pending),
        .level_o       (level),
        .rd_cnt_o      (rd_cnt),
        .wr_cnt_o      (wr_cnt),
        .ovf_o         (ovf),
        .unf_o         (unf),
        .conflict_o    (conflict)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the edge, then events are released.
    task automatic tick();
        @(posedge sys_clk);
        #1;
        rx_evt  = '0;
        tx_evt  = '0;
        eot     = '0;
        clr     = '0;
        cnt_clr = 1'b0;
    endtask

    function automatic logic [31:0] lvl(input int ch);
        return 32'(level[ch*LVL_W +: LVL_W]);
    endfunction

    function automatic logic [31:0] rdc(input int ch);
        return 32'(rd_cnt[ch*CNT_W +: CNT_W]);
    endfunction

    function automatic logic [31:0] wrc(input int ch);
        return 32'(wr_cnt[ch*CNT_W +: CNT_W]);
    endfunction

    task automatic check_all_zero(input string tag);
        check_eq({tag, " rd_done"},  32'(rd_done),  0);
        check_eq({tag, " wr_done"},  32'(wr_done),  0);
        check_eq({tag, " pending"},  32'(pending),  0);
        check_eq({tag, " level"},    32'(level),    0);
        check_eq({tag, " rd_cnt"},   32'(rd_cnt),   0);
        check_eq({tag, " wr_cnt"},   32'(wr_cnt),   0);
        check_eq({tag, " ovf"},      32'(ovf),      0);
        check_eq({tag, " unf"},      32'(unf),      0);
        check_eq({tag, " conflict"}, 32'(conflict), 0);
    endtask

    initial begin
        rstn    = 1'b0;
        rx_evt  = '0;
        tx_evt  = '0;
        eot     = '0;
        clr     = '0;
        cnt_clr = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rstn = 1'b1;

        // rx, tx, rx on ch0 then three eots
        rx_evt = 2'b01; tick();
        tx_evt = 2'b01; tick();
        rx_evt = 2'b01; tick();
        check_eq("seq level3", lvl(0), 3);
        check_eq("seq pending", 32'(pending), 32'b01);
        eot = 2'b01; tick();
        check_eq("seq eot1 rd", 32'(rd_done), 32'b01);
        check_eq("seq eot1 wr", 32'(wr_done), 0);
        check_eq("seq eot1 rdcnt", rdc(0), 1);
        check_eq("seq eot1 level", lvl(0), 2);
        eot = 2'b01; tick();
        check_eq("seq eot2 rd", 32'(rd_done), 0);
        check_eq("seq eot2 wr", 32'(wr_done), 32'b01);
        eot = 2'b01; tick();
        check_eq("seq eot3 rd", 32'(rd_done), 32'b01);
        check_eq("seq eot3 wr", 32'(wr_done), 0);
        tick();
        check_eq("seq pulse end", 32'(rd_done | wr_done), 0);
        check_eq("seq rd_cnt", rdc(0), 2);
        check_eq("seq wr_cnt", wrc(0), 1);
        check_eq("seq level0", lvl(0), 0);
        check_eq("seq ch1 level", lvl(1), 0);

        // five writes on ch1, depth 4 -> overflow
        for (int i = 0; i < 5; i++) begin
            tx_evt = 2'b10; tick();
        end
        check_eq("ovf level", lvl(1), 4);
        check_eq("ovf flag", 32'(ovf), 32'b10);
        for (int i = 0; i < 4; i++) begin
            eot = 2'b10; tick();
            check_eq("ovf drain wr", 32'(wr_done), 32'b10);
        end
        tick();
        check_eq("ovf pending", 32'(pending), 0);
        check_eq("ovf wr_cnt sat", wrc(1), 3);
        check_eq("ovf ch0 wr_cnt", wrc(0), 1);
        clr = 2'b10; tick();
        check_eq("ovf clr", 32'(ovf), 0);
        check_eq("clr keeps cnt", wrc(1), 3);

        // conflict on ch0
        rx_evt = 2'b01; tick();
        rx_evt = 2'b01; tx_evt = 2'b01; tick();
        check_eq("conf level", lvl(0), 1);
        check_eq("conf flag", 32'(conflict), 32'b01);
        clr = 2'b01; tick();
        check_eq("conf clr flag", 32'(conflict), 0);
        check_eq("conf clr level", lvl(0), 0);

        // eot on empty queue with concurrent launch
        eot = 2'b01; rx_evt = 2'b01; tick();
        check_eq("unf pulse", 32'(rd_done | wr_done), 0);
        check_eq("unf flag", 32'(unf), 32'b01);
        check_eq("unf level", lvl(0), 1);
        eot = 2'b01; tick();
        check_eq("unf next rd", 32'(rd_done), 32'b01);
        clr = 2'b01; tick();
        check_eq("unf clr", 32'(unf), 0);

        // push plus pop while full
        for (int i = 0; i < 4; i++) begin
            tx_evt = 2'b01; tick();
        end
        rx_evt = 2'b01; eot = 2'b01; tick();
        check_eq("full pp wr", 32'(wr_done), 32'b01);
        check_eq("full pp level", lvl(0), 4);
        check_eq("full pp ovf", 32'(ovf), 0);
        clr = 2'b01; cnt_clr = 1'b1; tick();
        check_eq("cnt_clr", rdc(0) | wrc(0), 0);

        // read count saturation and cnt_clr priority
        for (int i = 0; i < 5; i++) begin
            rx_evt = 2'b01; tick();
            eot = 2'b01; tick();
        end
        check_eq("sat rd_cnt", rdc(0), 3);
        rx_evt = 2'b01; tick();
        eot = 2'b01; cnt_clr = 1'b1; tick();
        check_eq("cnt_clr pulse", 32'(rd_done), 32'b01);
        check_eq("cnt_clr wins", rdc(0), 0);

        // reset mid-transfer
        rx_evt = 2'b11; tick();
        rx_evt = 2'b01; tick();
        check_eq("pre-rst level0", lvl(0), 2);
        check_eq("pre-rst level1", lvl(1), 1);
        rstn = 1'b0; tick();
        check_all_zero("mid rst");
        rstn = 1'b1;
        eot = 2'b01; tick();
        check_eq("post-rst pulse", 32'(rd_done | wr_done), 0);
        check_eq("post-rst unf", 32'(unf), 32'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/hyper_evt_tracker.md
HYPER_EVT_TRACKER -- requirements
Module: hyper_evt_tracker

Interface
REQ-001 SHALL take parameter NB_CH, 2, number of independent HyperBus transfer channels (1..4).
REQ-002 SHALL take parameter DEPTH, 4, per-channel outstanding-transfer queue depth (power of 2, 2..16).
REQ-003 SHALL take parameter CNT_W, 16, width of each per-channel completion counter.
REQ-004 SHALL expose port sys_clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL expose port rstn_i  input  1  reset, synchronous and active-low.
REQ-006 SHALL expose port rx_evt_i  input  NB_CH  per-channel pulse: read transfer launched (RX linear channel event).
REQ-007 SHALL expose port tx_evt_i  input  NB_CH  per-channel pulse: write transfer launched (TX linear channel event).
REQ-008 SHALL expose port eot_i  input  NB_CH  per-channel pulse: controller end-of-transfer.
REQ-009 SHALL expose port clr_i  input  NB_CH  per-channel flush of queue and sticky flags.
REQ-010 SHALL expose port cnt_clr_i  input  1  clears all completion counters.
REQ-011 SHALL expose port evt_rd_done_o  output  NB_CH  one-cycle pulse: read transfer completed.
REQ-012 SHALL expose port evt_wr_done_o  output  NB_CH  one-cycle pulse: write transfer completed.
REQ-013 SHALL expose port pending_o  output  NB_CH  channel queue non-empty.
REQ-014 SHALL expose port level_o  output  NB_CH*$clog2(DEPTH+1)  per-channel queue occupancy, channel 0 in LSBs.
REQ-015 SHALL expose port rd_cnt_o  output  NB_CH*CNT_W  per-channel read completion count, channel 0 in LSBs.
REQ-016 SHALL expose port wr_cnt_o  output  NB_CH*CNT_W  per-channel write completion count.
REQ-017 SHALL expose port ovf_o  output  NB_CH  sticky: launch dropped, queue full.
REQ-018 SHALL expose port unf_o  output  NB_CH  sticky: eot with empty queue.
REQ-019 SHALL expose port conflict_o  output  NB_CH  sticky: rx_evt_i and tx_evt_i same cycle.

Function
REQ-020 SHALL keep per channel an in-order FIFO of direction bits (1=read, 0=write), DEPTH entries, wrapping read/write pointers plus occupancy counter.
REQ-021 SHALL push 1 on rx_evt_i only, push 0 on tx_evt_i only; rx_evt_i and tx_evt_i together SHALL push nothing and set conflict_o.
REQ-022 SHALL pop head on eot_i when queue non-empty, pulsing evt_rd_done_o (head=1) or evt_wr_done_o (head=0) exactly one cycle after eot_i.
REQ-023 SHALL, on eot_i with empty queue (including an empty queue receiving a push the same cycle), emit no done pulse and set unf_o; the push still occurs.
REQ-024 SHALL, when full, drop a push without a same-cycle pop and set ovf_o; push plus pop while full SHALL both occur, level unchanged, no ovf_o.
REQ-025 SHALL, with simultaneous push and pop on a non-empty queue, pop the old head and append the new entry; level unchanged.
REQ-026 SHALL give clr_i priority over all same-channel events that cycle: queue emptied, pointers/level to 0, ovf_o/unf_o/conflict_o cleared, no done pulse; counters unaffected.
REQ-027 SHALL increment rd_cnt_o/wr_cnt_o in the cycle the matching done pulse is asserted, saturating at 2^CNT_W-1.
REQ-028 SHALL give cnt_clr_i priority over a same-cycle increment (counter becomes 0).
REQ-029 SHALL register all outputs; pending_o and level_o reflect state after the previous edge (update latency 1 cycle).
REQ-030 SHALL keep channels fully independent; events on one channel never alter another.

Reset
REQ-031 SHALL, with rstn_i low at a rising edge, clear all queues, pointers, counters and sticky flags; every output reads 0 from the following cycle.
REQ-032 SHALL, on reset mid-transfer, discard outstanding entries; a later eot_i without a new launch sets unf_o.

Verification
REQ-033 SHALL verify: ch0 rx,tx,rx launches then 3 eot_i -> rd,wr,rd pulses each 1 cycle after eot_i; rd_cnt ch0=2, wr_cnt ch0=1, level 3->0.
REQ-034 SHALL verify: DEPTH=4, 5 tx launches on ch1 -> level 4, ovf_o[1]=1; then 4 eot_i -> 4 wr pulses, pending_o[1]=0.
REQ-035 SHALL verify: rx_evt_i and tx_evt_i same cycle on ch0 -> level unchanged, conflict_o[0]=1; clr_i[0] -> conflict_o[0]=0.
REQ-036 SHALL verify: eot_i on empty ch0 concurrent with rx_evt_i -> no pulse, unf_o[0]=1, level 1; next eot_i -> rd pulse.
REQ-037 SHALL verify: CNT_W=2, 5 reads completed -> rd_cnt=3 saturated; cnt_clr_i with concurrent eot_i -> count 0, pulse still emitted.
REQ-038 SHALL verify: rstn_i low with ch0 level 2 and ch1 level 1 -> all outputs 0 next cycle; eot_i afterwards -> unf_o set, no pulse.
